// File: rtl/seq_code_pkg.sv
// Shared definitions for the sequence code monitor: legal code points, FSM state type,
// and the successor/decode helpers for the 000->011->101->110 cycle.
package seq_code_pkg;

    localparam logic [2:0] CODE_P0 = 3'b000;
    localparam logic [2:0] CODE_P1 = 3'b011;
    localparam logic [2:0] CODE_P2 = 3'b101;
    localparam logic [2:0] CODE_P3 = 3'b110;

    // Wide enough for the largest supported lock threshold (7).
    localparam int RUN_W = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } mon_state_t;

    function automatic logic is_legal(input logic [2:0] code);
        logic ok;
        case (code)
            CODE_P0, CODE_P1, CODE_P2, CODE_P3: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] successor(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            CODE_P0: nxt = CODE_P1;
            CODE_P1: nxt = CODE_P2;
            CODE_P2: nxt = CODE_P3;
            CODE_P3: nxt = CODE_P0;
            default: nxt = CODE_P0;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] decode(input logic [2:0] code);
        logic [1:0] pos;
        case (code)
            CODE_P1: pos = 2'd1;
            CODE_P2: pos = 2'd2;
            CODE_P3: pos = 2'd3;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_code_monitor.sv
// Monitors a 3-bit cyclic counter code, locks after LOCK_CNT successor steps and flags breaks.
// Optional macro SEQ_MON_ERRCNT_EN builds the saturating violation counter on err_count.
//
// state  | meaning
// HUNT   | searching; counting consecutive successor transitions toward LOCK_CNT
// LOCKED | tracking; any sample other than the expected successor is a violation
module seq_code_monitor
    import seq_code_pkg::*;
#(
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       code_in,
    input  logic             code_valid,
    output logic [1:0]       idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    mon_state_t       state;
    logic [2:0]       prev_code;
    logic             prev_ok;
    logic [RUN_W-1:0] run_cnt;

    logic             legal;
    logic             is_succ;
    logic             viol;

    always_comb begin
        legal   = is_legal(code_in);
        is_succ = prev_ok && (code_in == successor(prev_code));
        viol    = code_valid && (state == LOCKED) && !is_succ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            prev_code <= CODE_P0;
            prev_ok   <= 1'b0;
            run_cnt   <= '0;
            idx       <= 2'd0;
            idx_valid <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            idx_valid <= 1'b0;
            err       <= 1'b0;
            if (code_valid) begin
                if (legal) begin
                    prev_code <= code_in;
                    prev_ok   <= 1'b1;
                    idx       <= decode(code_in);
                    idx_valid <= 1'b1;
                end else begin
                    prev_ok   <= 1'b0;
                end

                case (state)
                    HUNT: begin
                        // A successor is always a legal code, so is_succ implies legal.
                        if (is_succ) begin
                            if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_succ) begin
                            state   <= HUNT;
                            locked  <= 1'b0;
                            err     <= 1'b1;
                            run_cnt <= '0;
                        end
                    end
                    default: begin
                        state   <= HUNT;
                        locked  <= 1'b0;
                        run_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_MON_ERRCNT_EN
    sat_counter #(
        .width(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (viol),
        .count(err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_seq_code_monitor.sv
// Directed scoreboard bench for seq_code_monitor (LOCK_CNT=2, ERR_W=2).
module tb_seq_code_monitor;

    logic       clk;
    logic       reset;
    logic [2:0] code_in;
    logic       code_valid;
    logic [1:0] idx;
    logic       idx_valid;
    logic       locked;
    logic       err;
    logic [1:0] err_count;

    seq_code_monitor #(
        .LOCK_CNT(2),
        .ERR_W   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (code_in),
        .code_valid(code_valid),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs from the edge ending cycle N are compared at the following negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {idx_valid, idx, locked, err, err_count};
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got iv=%b idx=%0d lk=%b err=%b cnt=%0d, expected iv=%b idx=%0d lk=%b err=%b cnt=%0d",
                         e.name, got[6], got[5:4], got[3], got[2], got[1:0],
                         e.exp[6], e.exp[5:4], e.exp[3], e.exp[2], e.exp[1:0]);
            end
        end
    end

    // Drive one sample and queue the outputs expected after the edge that takes it.
    task automatic step(input logic r, input logic v, input logic [2:0] c,
                        input logic e_iv, input logic [1:0] e_idx, input logic e_lk,
                        input logic e_err, input logic [1:0] e_cnt, input string nm);
        exp_t e;
        logic [1:0] cnt;
`ifdef SEQ_MON_ERRCNT_EN
        cnt = e_cnt;
`else
        cnt = 2'd0;
        if (e_cnt != e_cnt) cnt = 2'd1;
`endif
        @(posedge clk);
        #1;
        reset      = r;
        code_valid = v;
        code_in    = c;
        e.cyc  = cyc + 1;
        e.exp  = {e_iv, e_idx, e_lk, e_err, cnt};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        code_in    = 3'b000;

        //   rst v  code    iv idx lk er cnt
        step(1, 0, 3'b000, 0, 0, 0, 0, 0, "reset_a");
        step(1, 0, 3'b000, 0, 0, 0, 0, 0, "reset_b");

        step(0, 1, 3'b000, 1, 0, 0, 0, 0, "lock_000");
        step(0, 1, 3'b011, 1, 1, 0, 0, 0, "lock_011");
        step(0, 1, 3'b101, 1, 2, 1, 0, 0, "lock_101");

        step(0, 1, 3'b110, 1, 3, 1, 0, 0, "wrap_110");
        step(0, 0, 3'b111, 0, 3, 1, 0, 0, "gap_1");
        step(0, 0, 3'b010, 0, 3, 1, 0, 0, "gap_2");
        step(0, 0, 3'b011, 0, 3, 1, 0, 0, "gap_3");
        step(0, 1, 3'b000, 1, 0, 1, 0, 0, "wrap_000");
        step(0, 1, 3'b011, 1, 1, 1, 0, 0, "wrap_011");

        step(0, 1, 3'b101, 1, 2, 1, 0, 0, "viol_pre_101");
        step(0, 1, 3'b011, 1, 1, 0, 1, 1, "viol_011");
        step(0, 1, 3'b101, 1, 2, 0, 0, 1, "viol_relock_101");
        step(0, 1, 3'b110, 1, 3, 1, 0, 1, "viol_relock_110");

        step(0, 1, 3'b111, 0, 3, 0, 1, 2, "illegal_111");
        step(0, 1, 3'b000, 1, 0, 0, 0, 2, "illegal_relock_000");
        step(0, 1, 3'b011, 1, 1, 0, 0, 2, "illegal_relock_011");
        step(0, 1, 3'b101, 1, 2, 1, 0, 2, "illegal_relock_101");

        step(0, 1, 3'b101, 1, 2, 0, 1, 3, "repeat_101");
        step(0, 1, 3'b010, 0, 2, 0, 0, 3, "hunt_illegal_no_err");
        step(0, 1, 3'b110, 1, 3, 0, 0, 3, "hunt_after_illegal");
        step(0, 1, 3'b000, 1, 0, 0, 0, 3, "hunt_run1");
        step(0, 1, 3'b011, 1, 1, 1, 0, 3, "hunt_lock");

        step(0, 1, 3'b000, 1, 0, 0, 1, 3, "sat_viol4");
        step(0, 1, 3'b011, 1, 1, 0, 0, 3, "sat_run1");
        step(0, 1, 3'b101, 1, 2, 1, 0, 3, "sat_lock");
        step(0, 1, 3'b100, 0, 2, 0, 1, 3, "sat_viol5");

        step(0, 1, 3'b000, 1, 0, 0, 0, 3, "hunt_restart");
        step(0, 1, 3'b101, 1, 2, 0, 0, 3, "hunt_wrong_legal");
        step(0, 1, 3'b110, 1, 3, 0, 0, 3, "hunt_run_again");
        step(0, 1, 3'b000, 1, 0, 1, 0, 3, "hunt_lock_again");

        step(1, 1, 3'b011, 0, 0, 0, 0, 0, "reset_wins");
        step(0, 1, 3'b011, 1, 1, 0, 0, 0, "post_reset_no_history");
        step(0, 1, 3'b101, 1, 2, 0, 0, 0, "post_reset_run1");
        step(0, 1, 3'b110, 1, 3, 1, 0, 0, "post_reset_lock");
        step(0, 0, 3'b000, 0, 3, 1, 0, 0, "final_idle");

        begin
            int waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
